fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter BIT_NUMBER, default 32: address width.
REQ-002 Parameter BOOT_DELAY, default 4: post-reset fetch hold cycles, legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 hazard  in  1  ID-stage data hazard.
REQ-006 branch_taken  in  1  branch resolved taken in EX.
REQ-007 branch_address  in  BIT_NUMBER  EX branch target.
REQ-008 mem_busy  in  1  MEM-stage memory not ready.
REQ-009 freeze_front  out  1  hold PC and IF/ID registers.
REQ-010 freeze_all  out  1  hold ID/EX, EX/MEM and MEM/WB registers.
REQ-011 flush  out  1  clear IF/ID and ID/EX to bubbles.
REQ-012 bubble  out  1  clear ID/EX only.
REQ-013 if_branch_taken  out  1  IF-stage PC mux select.
REQ-014 if_branch_address  out  BIT_NUMBER  IF-stage PC target.
REQ-015 state  out  2  FSM state: BOOT=0, RUN=1, MEM_WAIT=2; 3 unused.
REQ-016 stall_count  out  16  cycles with freeze_front=1 outside BOOT.

Function
REQ-017 All outputs SHALL be combinational from registered state and current inputs; no added latency.
REQ-018 BOOT SHALL drive freeze_front=1, flush=1 and all other control outputs 0.
REQ-019 BOOT SHALL decrement boot_cnt each cycle and transition to RUN on the cycle boot_cnt=0.
REQ-020 In BOOT, hazard, branch_taken and mem_busy SHALL be ignored.
REQ-021 RUN priority SHALL be: mem_busy > branch_taken > hazard.
REQ-022 RUN with mem_busy=1 SHALL drive freeze_front=1 and freeze_all=1 in that cycle and transition to MEM_WAIT.
REQ-023 If branch_taken=1 in that same cycle, the controller SHALL latch branch_address into the pending register and set pending=1.
REQ-024 RUN with mem_busy=0 and branch_taken=1 SHALL drive if_branch_taken=1, if_branch_address=branch_address, flush=1 and freeze_front=0.
REQ-025 In that case hazard SHALL be ignored.
REQ-026 RUN with only hazard=1 SHALL drive freeze_front=1 and bubble=1.
REQ-027 MEM_WAIT with mem_busy=1 SHALL drive freeze_front=1 and freeze_all=1.
REQ-028 In MEM_WAIT, if branch_taken=1 and pending=0, the controller SHALL latch the target and set pending=1.
REQ-029 A second branch_taken while pending=1 SHALL NOT overwrite the latched target.
REQ-030 MEM_WAIT with mem_busy=0 and pending=1 SHALL drive if_branch_taken=1 from the latched address and flush=1, clear pending, and transition to RUN.
REQ-031 In that cycle, live branch_taken SHALL be ignored as the same held branch.
REQ-032 MEM_WAIT with mem_busy=0 and pending=0 SHALL apply the RUN decision of REQ-021..026 and transition to RUN, or remain in MEM_WAIT if mem_busy=1.
REQ-033 When no branch is issued, if_branch_address SHALL equal branch_address.
REQ-034 stall_count SHALL increment by 1 per cycle with freeze_front=1 and state!=BOOT.
REQ-035 stall_count SHALL saturate at 16'hFFFF and never wrap.
REQ-036 Encoding 3 SHALL recover to BOOT on the next clock.

Reset
REQ-037 With rst=0 at a rising edge: state=BOOT, boot_cnt=BOOT_DELAY-1, pending=0, pending address=0, stall_count=0.
REQ-038 Reset SHALL override any operation in progress, including MEM_WAIT with pending=1; the latched branch is discarded.
REQ-039 Output values during and after reset SHALL follow REQ-018.

Structure
REQ-040 State encodings SHALL reside in the shared pipeline package, together with the BIT_NUMBER default and the stall counter width (16).
REQ-041 Saturating counter SHALL be a sub-module named stall_counter (inputs clk, rst, inc; output count).
REQ-042 The pending target SHALL use the existing pipeline Register module.

Verification
REQ-043 BOOT_DELAY=4: release rst -> freeze_front=1, flush=1 for exactly 4 cycles; state=RUN on cycle 5; stall_count=0.
REQ-044 RUN, branch_taken=1, branch_address=32'h0000_0040, hazard=1 -> same cycle if_branch_taken=1, address 0x40, flush=1, freeze_front=0, bubble=0.
REQ-045 RUN, hazard=1 for 2 cycles -> freeze_front=1, bubble=1 both cycles; stall_count=2.
REQ-046 mem_busy=1 for 3 cycles with branch_taken=1 to 0x80 throughout -> freeze_all=1 for 3 cycles, no redirect, then 1 cycle if_branch_taken=1 to 0x80 with flush=1; state back to RUN.
REQ-047 Same stimulus as REQ-046, with rst=0 in the 2nd busy cycle -> next cycle state=BOOT, pending=0, no redirect to 0x80 ever issued.
REQ-048 Force stall_count to 16'hFFFE, then hold hazard=1 for 3 cycles -> stall_count reads 0xFFFF and stays there.

Source files
------------

// File: rtl/fetch_controller_pkg.sv
// Shared pipeline definitions for the fetch controller: FSM encodings,
// default address width, stall counter width and the saturating increment.
package fetch_controller_pkg;

  localparam int unsigned BIT_NUMBER_DEFAULT = 32;
  localparam int unsigned STALL_W            = 16;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ILLEGAL  = 2'd3
  } fc_state_e;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == {STALL_W{1'b1}}) ? v : (v + {{(STALL_W-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Hazard/branch/memory inputs and pipeline control outputs of the fetch controller.
interface fetch_controller_if
  import fetch_controller_pkg::*;
#(
  parameter int unsigned BIT_NUMBER = BIT_NUMBER_DEFAULT
);

  logic                  hazard;
  logic                  branch_taken;
  logic [BIT_NUMBER-1:0] branch_address;
  logic                  mem_busy;
  logic                  freeze_front;
  logic                  freeze_all;
  logic                  flush;
  logic                  bubble;
  logic                  if_branch_taken;
  logic [BIT_NUMBER-1:0] if_branch_address;
  logic [1:0]            state;
  logic [STALL_W-1:0]    stall_count;

  modport master (
    output hazard, branch_taken, branch_address, mem_busy,
    input  freeze_front, freeze_all, flush, bubble,
    input  if_branch_taken, if_branch_address, state, stall_count
  );

  modport slave (
    input  hazard, branch_taken, branch_address, mem_busy,
    output freeze_front, freeze_all, flush, bubble,
    output if_branch_taken, if_branch_address, state, stall_count
  );

endinterface

// File: rtl/fetch_controller_register.sv
// Pipeline register with load enable, cleared by the synchronous active-low reset.
module Register #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage with enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= {WIDTH{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fetch_controller_stall_counter.sv
// Saturating count of front-end freeze cycles; holds at all-ones instead of wrapping.
module stall_counter
  import fetch_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [STALL_W-1:0] count
);

  logic [STALL_W-1:0] count_q;
  logic [STALL_W-1:0] count_d;

  // Next count
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = sat_inc(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= {STALL_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch/pipeline control FSM: boot hold, memory-wait freeze with a single held
// branch target, branch redirect and hazard bubbles. Outputs are combinational.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int unsigned BIT_NUMBER = BIT_NUMBER_DEFAULT,
  parameter int unsigned BOOT_DELAY = 4
) (
  input  logic               clk,
  input  logic               rst,
  fetch_controller_if.slave  fc
);

  localparam logic [7:0] BOOT_RELOAD = 8'(BOOT_DELAY - 1);

  fc_state_e             state_q, state_d;
  logic [7:0]            boot_cnt_q, boot_cnt_d;
  logic                  pending_q, pending_d;
  logic                  pend_en_s;
  logic [BIT_NUMBER-1:0] pend_addr_s;

  logic                  freeze_front_s, freeze_all_s, flush_s, bubble_s;
  logic                  if_branch_taken_s;
  logic [BIT_NUMBER-1:0] if_branch_address_s;
  logic                  stall_inc_s;

  // State, boot counter and pending flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= BOOT_RELOAD;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pending_q  <= pending_d;
    end
  end

  // Next-state logic; a branch seen while memory is busy is held only if none is held yet
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pending_d  = pending_q;
    pend_en_s  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q - 8'd1;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (fc.mem_busy) begin
          state_d = ST_MEM_WAIT;
          if (fc.branch_taken && !pending_q) begin
            pend_en_s = 1'b1;
            pending_d = 1'b1;
          end else begin
            pend_en_s = 1'b0;
          end
        end else begin
          state_d   = ST_RUN;
          pending_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        boot_cnt_d = BOOT_RELOAD;
        pending_d  = 1'b0;
      end
    endcase
  end

  Register #(.WIDTH(BIT_NUMBER)) u_pend_addr (
    .clk (clk),
    .rst (rst),
    .en  (pend_en_s),
    .d   (fc.branch_address),
    .q   (pend_addr_s)
  );

  // Control outputs; the held branch wins over live inputs when memory frees up
  always_comb begin
    freeze_front_s      = 1'b0;
    freeze_all_s        = 1'b0;
    flush_s             = 1'b0;
    bubble_s            = 1'b0;
    if_branch_taken_s   = 1'b0;
    if_branch_address_s = fc.branch_address;
    if ((state_q == ST_BOOT) || (state_q == ST_ILLEGAL)) begin
      freeze_front_s = 1'b1;
      flush_s        = 1'b1;
    end else if (fc.mem_busy) begin
      freeze_front_s = 1'b1;
      freeze_all_s   = 1'b1;
    end else if ((state_q == ST_MEM_WAIT) && pending_q) begin
      if_branch_taken_s   = 1'b1;
      if_branch_address_s = pend_addr_s;
      flush_s             = 1'b1;
    end else if (fc.branch_taken) begin
      if_branch_taken_s = 1'b1;
      flush_s           = 1'b1;
    end else if (fc.hazard) begin
      freeze_front_s = 1'b1;
      bubble_s       = 1'b1;
    end else begin
      freeze_front_s = 1'b0;
    end
  end

  assign stall_inc_s = freeze_front_s && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT));

  stall_counter u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .count (fc.stall_count)
  );

  assign fc.freeze_front      = freeze_front_s;
  assign fc.freeze_all        = freeze_all_s;
  assign fc.flush             = flush_s;
  assign fc.bubble            = bubble_s;
  assign fc.if_branch_taken   = if_branch_taken_s;
  assign fc.if_branch_address = if_branch_address_s;
  assign fc.state             = state_q;

endmodule
